// File: rtl/pipelined_carry_adder_if.sv
// Handshake bundle for pipelined_carry_adder: operand side, result side and,
// when SIGNED_OVF_EN is defined, the two's-complement overflow flag.
interface pipelined_carry_adder_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic         carry_in;
    logic [N-1:0] op1;
    logic [N-1:0] op2;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         carry_out;
`ifdef SIGNED_OVF_EN
    logic         ovf;

    modport master (
        output in_valid, carry_in, op1, op2, out_ready,
        input  in_ready, out_valid, sum, carry_out, ovf
    );

    modport slave (
        input  in_valid, carry_in, op1, op2, out_ready,
        output in_ready, out_valid, sum, carry_out, ovf
    );
`else
    modport master (
        output in_valid, carry_in, op1, op2, out_ready,
        input  in_ready, out_valid, sum, carry_out
    );

    modport slave (
        input  in_valid, carry_in, op1, op2, out_ready,
        output in_ready, out_valid, sum, carry_out
    );
`endif
endinterface

// File: rtl/pipelined_carry_adder.sv
// N-bit adder whose carry chain is split into STAGES registered chunks of N/STAGES bits.
// Define SIGNED_OVF_EN to add a pipelined two's-complement overflow output (bus.ovf).
module pipelined_carry_adder #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input logic                    clk,
    input logic                    rst,
    pipelined_carry_adder_if.slave bus
);
    localparam int W = (STAGES > 0) ? N / STAGES : 1;

    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_carry_adder: STAGES must divide N and lie in 1..N");
    end

    logic adv;

    // The whole pipeline moves as one; it only stalls when a finished result is refused.
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * W;

        logic [N-LO-1:0] a_in;
        logic [N-LO-1:0] b_in;
        logic            c_in;
        logic            v_in;
        logic [W:0]      chunk;
        logic [LO+W-1:0] s_next;
        logic [LO+W-1:0] s_r;
        logic            c_r;
        logic            v_r;

        // a_in/b_in hold the operand chunks this stage and all later stages still need.
        if (k == 0) begin : g_head
            assign a_in   = bus.op1;
            assign b_in   = bus.op2;
            assign c_in   = bus.carry_in;
            assign v_in   = bus.in_valid;
            assign s_next = chunk[W-1:0];
        end else begin : g_body
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_in <= '0;
                    b_in <= '0;
                end else if (adv) begin
                    a_in <= g_stage[k-1].a_in[N-LO+W-1:W];
                    b_in <= g_stage[k-1].b_in[N-LO+W-1:W];
                end
            end

            assign c_in   = g_stage[k-1].c_r;
            assign v_in   = g_stage[k-1].v_r;
            assign s_next = {chunk[W-1:0], g_stage[k-1].s_r};
        end

        assign chunk = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (adv) begin
                v_r <= v_in;
                c_r <= chunk[W];
                s_r <= s_next;
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].v_r;
    assign bus.sum       = g_stage[STAGES-1].s_r;
    assign bus.carry_out = g_stage[STAGES-1].c_r;

`ifdef SIGNED_OVF_EN
    logic ovf_next;
    logic ovf_r;

    // Carry into the MSB is recovered as a^b^sum at that bit, then compared with carry out.
    assign ovf_next = g_stage[STAGES-1].a_in[W-1] ^ g_stage[STAGES-1].b_in[W-1]
                    ^ g_stage[STAGES-1].chunk[W-1] ^ g_stage[STAGES-1].chunk[W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (adv) begin
            ovf_r <= ovf_next;
        end
    end

    assign bus.ovf = ovf_r;
`endif
endmodule
